// File: rtl/sd_cmd_sched.sv
// sd_cmd_sched: arbitrates software and data-master commands onto the SD CMD line, enforcing timeout and keeping interrupt status
module sd_cmd_sched #(
  parameter int PRESCALE = 64,
  parameter int PRE_W = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        sw_req,
  input  logic [15:0] sw_cmd_set,
  input  logic [31:0] sw_arg,
  input  logic        dm_req,
  input  logic [15:0] dm_cmd_set,
  input  logic [31:0] dm_arg,
  output logic        dm_ack,
  output logic        dm_done,
  output logic        dm_err,
  output logic        sw_busy,
  output logic        cmd_start,
  output logic        cmd_abort,
  output logic [15:0] cmd_setting_o,
  output logic [31:0] cmd_arg_o,
  input  logic        cmd_done_i,
  input  logic        cmd_crc_err_i,
  input  logic        cmd_idx_err_i,
  input  logic [31:0] resp_i,
  output logic [31:0] resp_o,
  input  logic [15:0] time_out_reg,
  input  logic        normal_isr_reset,
  input  logic        error_isr_reset,
  output logic [15:0] normal_int_status,
  output logic [15:0] error_int_status
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;
  state_t state_q, state_d;
  // owner/last: 1 = data master, 0 = software
  logic sw_pend_q, sw_pend_d, owner_q, owner_d, last_q, last_d;
  logic [15:0] set_q, set_d;
  logic [31:0] arg_q, arg_d, resp_q, resp_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0] tick_q, tick_d, tick_nxt;
  logic to_q, to_d, crc_q, crc_d, idx_q, idx_d;
  logic start_q, start_d, abort_q, abort_d, ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [15:0] normal_q, normal_d, error_q, error_d;
  logic sw_cand, grant_sw, wrap, any_err;
  assign sw_cand = sw_pend_q | sw_req;
  assign grant_sw = sw_cand & (~dm_req | last_q);
  assign wrap = pre_q == PRE_W'(PRESCALE - 1);
  assign tick_nxt = tick_q + 16'(wrap && tick_q != 16'hFFFF);
  assign any_err = to_q | crc_q | idx_q;
  assign dm_ack = ack_q;
  assign dm_done = done_q;
  assign dm_err = err_q;
  assign sw_busy = sw_pend_q | (~owner_q && state_q != IDLE);
  assign cmd_start = start_q;
  assign cmd_abort = abort_q;
  assign cmd_setting_o = set_q;
  assign cmd_arg_o = arg_q;
  assign resp_o = resp_q;
  assign normal_int_status = normal_q;
  assign error_int_status = error_q;
  // next-state: arbitration, command sequencing, timeout and sticky status
  always_comb begin
    state_d = state_q;
    sw_pend_d = sw_pend_q | sw_req;
    owner_d = owner_q;
    last_d = last_q;
    set_d = set_q;
    arg_d = arg_q;
    resp_d = resp_q;
    pre_d = pre_q;
    tick_d = tick_q;
    to_d = to_q;
    crc_d = crc_q;
    idx_d = idx_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    ack_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    normal_d = normal_isr_reset ? 16'h0 : normal_q;
    error_d = error_isr_reset ? 16'h0 : error_q;
    case (state_q)
      IDLE: if (sw_cand || dm_req) begin
        state_d = ISSUE;
        owner_d = ~grant_sw;
        set_d = grant_sw ? sw_cmd_set : dm_cmd_set;
        arg_d = grant_sw ? sw_arg : dm_arg;
        ack_d = ~grant_sw;
        sw_pend_d = grant_sw ? 1'b0 : sw_pend_d;
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        start_d = 1'b1;
        pre_d = '0;
        tick_d = '0;
        to_d = 1'b0;
        crc_d = 1'b0;
        idx_d = 1'b0;
      end
      WAIT_DONE: begin
        pre_d = wrap ? '0 : pre_q + PRE_W'(1);
        tick_d = tick_nxt;
        if (cmd_done_i) begin
          state_d = COMPLETE;
          crc_d = cmd_crc_err_i;
          idx_d = cmd_idx_err_i;
          resp_d = (!cmd_crc_err_i && !cmd_idx_err_i && set_q[1:0] != 2'b00) ? resp_i : resp_q;
        end else if (time_out_reg != 16'h0 && tick_nxt == time_out_reg) begin
          state_d = COMPLETE;
          abort_d = 1'b1;
          to_d = 1'b1;
        end
      end
      COMPLETE: begin
        state_d = IDLE;
        error_d = error_d | {12'h0, idx_q, 1'b0, crc_q, to_q};
        normal_d = normal_d | {any_err, 14'h0, ~any_err};
        done_d = owner_q;
        err_d = owner_q & any_err;
        last_d = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous reset; reset abandons any command silently
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sw_pend_q <= 1'b0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      set_q <= '0;
      arg_q <= '0;
      resp_q <= '0;
      pre_q <= '0;
      tick_q <= '0;
      to_q <= 1'b0;
      crc_q <= 1'b0;
      idx_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      ack_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      normal_q <= '0;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      sw_pend_q <= sw_pend_d;
      owner_q <= owner_d;
      last_q <= last_d;
      set_q <= set_d;
      arg_q <= arg_d;
      resp_q <= resp_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      to_q <= to_d;
      crc_q <= crc_d;
      idx_q <= idx_d;
      start_q <= start_d;
      abort_q <= abort_d;
      ack_q <= ack_d;
      done_q <= done_d;
      err_q <= err_d;
      normal_q <= normal_d;
      error_q <= error_d;
    end
  end
endmodule

// File: tb/tb_sd_cmd_sched.sv
// tb_sd_cmd_sched: directed checks of arbitration, latency, timeout, status and reset
module tb_sd_cmd_sched;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic sw_req = 1'b0, dm_req = 1'b0;
  logic [15:0] sw_cmd_set = '0, dm_cmd_set = '0, time_out_reg = '0;
  logic [31:0] sw_arg = '0, dm_arg = '0, resp_i = '0;
  logic dm_ack, dm_done, dm_err, sw_busy, cmd_start, cmd_abort;
  logic [15:0] cmd_setting_o, normal_int_status, error_int_status;
  logic [31:0] cmd_arg_o, resp_o;
  logic cmd_done_i = 1'b0, cmd_crc_err_i = 1'b0, cmd_idx_err_i = 1'b0;
  logic normal_isr_reset = 1'b0, error_isr_reset = 1'b0;
  int errors = 0, checks = 0;
  int n_start = 0, n_ack = 0, n_abort = 0;
  int a0, s0;

  sd_cmd_sched #(.PRESCALE(4), .PRE_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .sw_req(sw_req), .sw_cmd_set(sw_cmd_set), .sw_arg(sw_arg),
    .dm_req(dm_req), .dm_cmd_set(dm_cmd_set), .dm_arg(dm_arg),
    .dm_ack(dm_ack), .dm_done(dm_done), .dm_err(dm_err), .sw_busy(sw_busy),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cmd_setting_o(cmd_setting_o), .cmd_arg_o(cmd_arg_o),
    .cmd_done_i(cmd_done_i), .cmd_crc_err_i(cmd_crc_err_i), .cmd_idx_err_i(cmd_idx_err_i),
    .resp_i(resp_i), .resp_o(resp_o), .time_out_reg(time_out_reg),
    .normal_isr_reset(normal_isr_reset), .error_isr_reset(error_isr_reset),
    .normal_int_status(normal_int_status), .error_int_status(error_int_status)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (cmd_start) n_start++;
    if (dm_ack) n_ack++;
    if (cmd_abort) n_abort++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_status();
    normal_isr_reset = 1'b1;
    error_isr_reset = 1'b1;
    step();
    normal_isr_reset = 1'b0;
    error_isr_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_normal", normal_int_status, 0);
    check("rst_error", error_int_status, 0);
    check("rst_resp", resp_o, 0);
    check("rst_setting", cmd_setting_o, 0);
    check("rst_busy", sw_busy, 0);
    check("rst_start", cmd_start, 0);
    wb_rst_i = 1'b0;
    // software-only command
    sw_req = 1'b1; sw_cmd_set = 16'h1101; sw_arg = 32'h0000_0200;
    step();
    sw_req = 1'b0;
    check("t1_setting", cmd_setting_o, 32'h1101);
    check("t1_arg", cmd_arg_o, 32'h200);
    check("t1_busy", sw_busy, 1);
    check("t1_start_early", cmd_start, 0);
    step();
    check("t1_start", cmd_start, 1);
    repeat (8) step();
    cmd_done_i = 1'b1; resp_i = 32'h0000_0900;
    step();
    cmd_done_i = 1'b0;
    check("t1_normal_d1", normal_int_status, 0);
    step();
    check("t1_normal", normal_int_status, 16'h0001);
    check("t1_error", error_int_status, 0);
    check("t1_resp", resp_o, 32'h900);
    check("t1_busy_end", sw_busy, 0);
    check("t1_start_cnt", n_start, 1);
    check("t1_ack_cnt", n_ack, 0);
    // simultaneous requests after reset: software first
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    check("t2_rst_normal", normal_int_status, 0);
    sw_req = 1'b1; sw_cmd_set = 16'h0D01; sw_arg = 32'h11;
    dm_req = 1'b1; dm_cmd_set = 16'h1112; dm_arg = 32'h4000;
    step();
    sw_req = 1'b0;
    check("t2_sw_setting", cmd_setting_o, 32'h0D01);
    check("t2_no_ack", dm_ack, 0);
    step();
    check("t2_sw_start", cmd_start, 1);
    repeat (3) step();
    cmd_done_i = 1'b1; resp_i = 32'h0000_0ABC;
    step();
    cmd_done_i = 1'b0;
    step();
    check("t2_ack_d2", dm_ack, 0);
    check("t2_normal", normal_int_status, 16'h0001);
    check("t2_resp_sw", resp_o, 32'hABC);
    step();
    check("t2_ack", dm_ack, 1);
    check("t2_dm_setting", cmd_setting_o, 32'h1112);
    check("t2_dm_arg", cmd_arg_o, 32'h4000);
    dm_req = 1'b0;
    step();
    check("t2_dm_start", cmd_start, 1);
    check("t2_ack_pulse", dm_ack, 0);
    step();
    step();
    cmd_done_i = 1'b1; resp_i = 32'h0000_0DEF;
    step();
    cmd_done_i = 1'b0;
    check("t2_done_early", dm_done, 0);
    step();
    check("t2_dm_done", dm_done, 1);
    check("t2_dm_err", dm_err, 0);
    check("t2_resp_dm", resp_o, 32'hDEF);
    step();
    check("t2_done_pulse", dm_done, 0);
    // timeout, PRESCALE 4 and 3 ticks
    clear_status();
    check("t3_cleared", normal_int_status, 0);
    time_out_reg = 16'd3;
    sw_req = 1'b1; sw_cmd_set = 16'h0801;
    step();
    sw_req = 1'b0;
    step();
    check("t3_start", cmd_start, 1);
    a0 = n_abort;
    repeat (11) step();
    check("t3_abort_early", cmd_abort, 0);
    step();
    check("t3_abort", cmd_abort, 1);
    check("t3_error_early", error_int_status, 0);
    step();
    check("t3_abort_pulse", cmd_abort, 0);
    check("t3_error", error_int_status, 16'h0001);
    check("t3_normal", normal_int_status, 16'h8000);
    cmd_done_i = 1'b1; cmd_crc_err_i = 1'b1; resp_i = 32'h5555;
    step();
    cmd_done_i = 1'b0; cmd_crc_err_i = 1'b0;
    step();
    step();
    check("t3_late_error", error_int_status, 16'h0001);
    check("t3_late_resp", resp_o, 32'hDEF);
    check("t3_abort_cnt", n_abort - a0, 1);
    time_out_reg = 16'd0;
    // data-master command with CRC error
    clear_status();
    check("t4_cleared", error_int_status, 0);
    dm_req = 1'b1; dm_cmd_set = 16'h1111; dm_arg = 32'h8;
    step();
    check("t4_ack", dm_ack, 1);
    dm_req = 1'b0;
    step();
    check("t4_start", cmd_start, 1);
    step();
    cmd_done_i = 1'b1; cmd_crc_err_i = 1'b1; resp_i = 32'h1234_5678;
    step();
    cmd_done_i = 1'b0; cmd_crc_err_i = 1'b0;
    step();
    check("t4_dm_done", dm_done, 1);
    check("t4_dm_err", dm_err, 1);
    check("t4_error", error_int_status, 16'h0002);
    check("t4_normal", normal_int_status, 16'h8000);
    check("t4_resp", resp_o, 32'hDEF);
    // normal clear coinciding with COMPLETE, then clear alone
    clear_status();
    sw_req = 1'b1; sw_cmd_set = 16'h0001;
    step();
    sw_req = 1'b0;
    step();
    step();
    cmd_done_i = 1'b1; resp_i = 32'h77;
    step();
    cmd_done_i = 1'b0;
    normal_isr_reset = 1'b1;
    step();
    normal_isr_reset = 1'b0;
    check("t5_set_wins", normal_int_status, 16'h0001);
    check("t5_resp", resp_o, 32'h77);
    step();
    normal_isr_reset = 1'b1;
    step();
    normal_isr_reset = 1'b0;
    check("t5_cleared", normal_int_status, 0);
    // index error on a software command
    sw_req = 1'b1; sw_cmd_set = 16'h0002;
    step();
    sw_req = 1'b0;
    step();
    step();
    cmd_done_i = 1'b1; cmd_idx_err_i = 1'b1; resp_i = 32'hAAAA;
    step();
    cmd_done_i = 1'b0; cmd_idx_err_i = 1'b0;
    step();
    check("t5_idx_error", error_int_status, 16'h0008);
    check("t5_idx_normal", normal_int_status, 16'h8000);
    check("t5_idx_resp", resp_o, 32'h77);
    // reset during WAIT_DONE with a queued software command
    sw_req = 1'b1; sw_cmd_set = 16'h0101;
    step();
    sw_req = 1'b0;
    step();
    sw_req = 1'b1;
    step();
    sw_req = 1'b0;
    check("t6_busy", sw_busy, 1);
    step();
    wb_rst_i = 1'b1;
    step();
    wb_rst_i = 1'b0;
    check("t6_setting", cmd_setting_o, 0);
    check("t6_arg", cmd_arg_o, 0);
    check("t6_busy_rst", sw_busy, 0);
    check("t6_normal", normal_int_status, 0);
    check("t6_error", error_int_status, 0);
    check("t6_resp", resp_o, 0);
    check("t6_abort", cmd_abort, 0);
    a0 = n_abort;
    s0 = n_start;
    dm_req = 1'b1; dm_cmd_set = 16'h0200; dm_arg = 32'h99;
    step();
    check("t6_ack", dm_ack, 1);
    check("t6_dm_setting", cmd_setting_o, 32'h0200);
    dm_req = 1'b0;
    step();
    check("t6_start", cmd_start, 1);
    step();
    cmd_done_i = 1'b1;
    step();
    cmd_done_i = 1'b0;
    step();
    check("t6_dm_done", dm_done, 1);
    check("t6_dm_err", dm_err, 0);
    repeat (4) step();
    check("t6_no_abort", n_abort - a0, 0);
    check("t6_one_start", n_start - s0, 1);
    check("t6_busy_end", sw_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_cmd_sched.md
Name: sd_cmd_sched

Overview:
- Command scheduler between the SD wishbone register file and the CMD-line serial host.
- Two requesters share the single command path:
  - software: a write to the argument register;
  - internal data master: BD-driven CMD17/CMD24 requests.
- Arbitrates between them, sequences one command at a time, enforces the response timeout, captures the response, and maintains sticky normal/error interrupt status bits.

Parameters:
- PRESCALE, 64, wb_clk_i cycles per timeout tick (≥1).
- PRE_W, 8, prescaler counter width; requires PRESCALE ≤ 2^PRE_W.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset
- sw_req  in  1  one-cycle pulse: software issued a command
- sw_cmd_set  in  16  software command setting; bits [1:0] are the response type (00 = none)
- sw_arg  in  32  software argument
- dm_req  in  1  level: data-master request, held until dm_ack
- dm_cmd_set  in  16  data-master command setting
- dm_arg  in  32  data-master argument
- dm_ack  out  1  pulse: data-master request granted
- dm_done  out  1  pulse: data-master command finished
- dm_err  out  1  qualifies dm_done: finished with an error
- sw_busy  out  1  software command pending or in flight
- cmd_start  out  1  pulse to the serial host
- cmd_abort  out  1  pulse on timeout
- cmd_setting_o  out  16  command setting to the host
- cmd_arg_o  out  32  argument to the host
- cmd_done_i  in  1  pulse from the host: command/response finished
- cmd_crc_err_i  in  1  qualifies cmd_done_i
- cmd_idx_err_i  in  1  qualifies cmd_done_i
- resp_i  in  32  response from the host
- resp_o  out  32  captured response
- time_out_reg  in  16  timeout in ticks; 0 = disabled
- normal_isr_reset  in  1  clear normal status
- error_isr_reset  in  1  clear error status
- normal_int_status  out  16  bit0 = cmd complete, bit15 = error summary, others 0
- error_int_status  out  16  bit0 = timeout, bit1 = CRC, bit3 = index, others 0

Behaviour:
- Clocking: one clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; sw_pend = 0; last_owner = dm, so software wins the first tie. Reset mid-command abandons it silently: no abort, no status update.
- sw_pend: set on sw_req in any state; cleared at software grant. A sw_req during a software command in flight queues exactly one more command. Multiple sw_reqs before the grant collapse into one.
- sw_busy = sw_pend | (owner == sw and state != IDLE).
- States: IDLE → ISSUE → WAIT_DONE → COMPLETE → IDLE.
- IDLE:
  - Candidates are sw = sw_pend | sw_req, and dm = dm_req.
  - If only one candidate is present, grant it.
  - If both are present, grant the one that is not last_owner (alternating round-robin).
  - On grant, register the winner's cmd_set/arg into cmd_setting_o/cmd_arg_o and record owner. Go to ISSUE.
  - For a dm grant, dm_ack pulses in the same cycle cmd_setting_o becomes valid.
- ISSUE:
  - cmd_start = 1 for exactly one cycle.
  - Clear the prescaler and tick counter. Go to WAIT_DONE.
  - cmd_setting_o/cmd_arg_o are held stable from ISSUE until back in IDLE.
- WAIT_DONE:
  - Prescaler counts 0..PRESCALE-1; on wrap, the tick counter increments (16 bits, saturating).
  - cmd_done_i has priority over timeout in the same cycle.
  - On cmd_done_i: latch the error flags. If no error and the response type ≠ 00, set resp_o = resp_i. Go to COMPLETE.
  - Else if time_out_reg ≠ 0 and tick == time_out_reg: cmd_abort = 1 for one cycle, latch the timeout flag, go to COMPLETE.
- COMPLETE (one cycle):
  - Set error_int_status bits from the latched flags.
  - Set normal bit0 if no error, bit15 if any error.
  - If owner == dm, pulse dm_done with dm_err.
  - Update last_owner. Go to IDLE.
- Status bits are sticky; each clear input zeroes its whole register. If a set and a clear coincide, the set wins.
- Latency:
  - sw_req at cycle N (IDLE): grant/setting valid N+1, cmd_start N+2.
  - cmd_done_i at D: status visible D+2, IDLE at D+2, earliest next cmd_start D+4.
- cmd_done_i outside WAIT_DONE is ignored.

Test Plan:
- Software-only command, cmd_set = 0x1101, arg = 0x0000_0200, host done at +10 cycles with resp_i = 0x0000_0900:
  - cmd_start fires exactly once, 2 cycles after sw_req;
  - resp_o = 0x900, normal = 0x0001, error = 0x0000; dm_ack never asserts.
- sw_req and dm_req in the same IDLE cycle, after reset:
  - software granted first; dm_ack pulses in the cycle the software command returns to IDLE;
  - dm_done pulses with dm_err = 0; the setting sequence is sw then dm.
- Timeout with PRESCALE = 4, time_out_reg = 3, no cmd_done_i:
  - cmd_abort pulses at cycle 12 after ISSUE;
  - error = 0x0001, normal = 0x8000; a late cmd_done_i is ignored.
- cmd_done_i with cmd_crc_err_i = 1 for a dm command:
  - dm_done = 1 with dm_err = 1; error = 0x0002; resp_o unchanged.
- normal_isr_reset in the same cycle as COMPLETE:
  - normal bit0 remains 1; a later reset alone clears it to 0.
- wb_rst_i asserted during WAIT_DONE:
  - next cycle state IDLE, all outputs 0, sw_pend cleared;
  - a subsequent dm_req is granted normally.
